// File: rtl/hack_alu_ctrl.sv
// rtl/hack_alu_ctrl.sv - Hack instruction sequencer driving an external ALU
module hack_alu_ctrl #(
    parameter logic [14:0] RESET_PC = 15'd0,
    parameter int          WORD     = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [WORD-1:0] instr,
    input  logic            instr_valid,
    output logic            instr_ready,
    output logic [14:0]     pc,
    input  logic [WORD-1:0] in_m,
    output logic [WORD-1:0] alu_x,
    output logic [WORD-1:0] alu_y,
    output logic            zx,
    output logic            nx,
    output logic            zy,
    output logic            ny,
    output logic            f,
    output logic            no,
    input  logic [WORD-1:0] alu_out,
    input  logic            alu_zr,
    input  logic            alu_ng,
    output logic [WORD-1:0] out_m,
    output logic            write_m,
    output logic [14:0]     address_m,
    output logic            busy
);

    typedef enum logic [1:0] {
        FETCH,
        EXEC,
        COMMIT
    } state_t;

    state_t          state;
    logic [WORD-1:0] a_reg;
    logic [WORD-1:0] d_reg;
    logic [WORD-1:0] ir;
    logic [WORD-1:0] result;
    logic            zr_q;
    logic            ng_q;
    logic            in_exec;
    logic            jump;

    // ALU stimulus is only presented while the instruction is executing so
    // the combinational ALU sees quiet inputs in every other cycle.
    always_comb begin
        in_exec = (state == EXEC) && !reset;
        alu_x   = '0;
        alu_y   = '0;
        {zx, nx, zy, ny, f, no} = 6'b0;
        if (in_exec) begin
            alu_x = d_reg;
            alu_y = ir[12] ? in_m : a_reg;
            {zx, nx, zy, ny, f, no} = ir[11:6];
        end
    end

    assign jump        = (ir[2] & ng_q) | (ir[1] & zr_q) | (ir[0] & ~ng_q & ~zr_q);
    assign instr_ready = (state == FETCH) && !reset;
    assign busy        = (state != FETCH);
    assign write_m     = (state == COMMIT) && ir[15] && ir[3] && !reset;
    assign out_m       = result;
    assign address_m   = a_reg[14:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= FETCH;
            a_reg  <= '0;
            d_reg  <= '0;
            ir     <= '0;
            result <= '0;
            zr_q   <= 1'b0;
            ng_q   <= 1'b0;
            pc     <= RESET_PC;
        end else begin
            case (state)
                FETCH: begin
                    if (instr_valid) begin
                        ir    <= instr;
                        state <= instr[15] ? EXEC : COMMIT;
                    end
                end
                EXEC: begin
                    result <= alu_out;
                    zr_q   <= alu_zr;
                    ng_q   <= alu_ng;
                    state  <= COMMIT;
                end
                COMMIT: begin
                    if (!ir[15]) begin
                        a_reg <= {1'b0, ir[14:0]};
                        pc    <= pc + 15'd1;
                    end else begin
                        // Jump target and memory address both use A as it was
                        // before this commit, even when A is also a destination.
                        if (ir[5]) a_reg <= result;
                        if (ir[4]) d_reg <= result;
                        pc <= jump ? a_reg[14:0] : pc + 15'd1;
                    end
                    state <= FETCH;
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: doc/hack_alu_ctrl.md
Name: hack_alu_ctrl

Overview:
Multi-cycle Hack instruction decoder and sequencer that produces the operand and control stimulus consumed by the 16-bit ALU. It then captures the ALU's out/zr/ng results. It owns the A, D and PC registers, fetches one instruction per handshake, drives zx/nx/zy/ny/f/no from the C-instruction comp field, and commits results to A/D/memory and the program counter. It sits between instruction ROM, data memory and the combinational ALU.

Parameters:
RESET_PC, 0, PC value loaded on reset (15-bit).
WORD, 16, datapath width; only 16 is supported.

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
instr  in  16  instruction word from ROM
instr_valid  in  1  instr is valid this cycle
instr_ready  out  1  block accepts instr this cycle
pc  out  15  address of the next instruction to fetch
in_m  in  16  data memory read value at address_m
alu_x  out  16  ALU x operand
alu_y  out  16  ALU y operand
zx, nx, zy, ny, f, no  out  1 each  ALU control bits
alu_out  in  16  ALU result
alu_zr  in  1  ALU zero flag
alu_ng  in  1  ALU negative flag
out_m  out  16  memory write data
write_m  out  1  memory write strobe, one cycle
address_m  out  15  memory address, always A[14:0]
busy  out  1  high when not in FETCH

Behaviour:
- Reset has priority over everything. A=0, D=0, IR=0, result=0, pc=RESET_PC, state=FETCH, write_m=0, all ALU controls=0, alu_x=alu_y=0. Reset in any state aborts the instruction with no A/D/M/PC side effects.
- States: FETCH, EXEC, COMMIT.
- FETCH:
  - instr_ready=1.
  - On instr_valid & instr_ready, latch IR=instr.
  - If instr[15]=0 (A-instruction), go to COMMIT. Otherwise go to EXEC.
  - With no valid, hold in FETCH.
- EXEC (C-instruction only):
  - alu_x=D.
  - alu_y = in_m if IR[12]=1, else A.
  - zx,nx,zy,ny,f,no = IR[11:6] (zx=IR[11] ... no=IR[6]).
  - At the clock edge, register result=alu_out, zr_q=alu_zr, ng_q=alu_ng. Go to COMMIT.
  - Outside EXEC, alu_x, alu_y and all six controls are driven 0.
- COMMIT, A-instruction:
  - A <= {1'b0, IR[14:0]}; pc <= pc+1.
  - No D or memory write.
- COMMIT, C-instruction:
  - d-bits: IR[5] loads A <= result, IR[4] loads D <= result, IR[3] pulses write_m=1 with out_m=result.
  - address_m and any jump target use the pre-commit A value. When A and M are both destinations, the write goes to the old A.
  - Jump taken = (IR[2] & ng_q) | (IR[1] & zr_q) | (IR[0] & ~ng_q & ~zr_q).
  - If taken, pc <= old A[14:0]; otherwise pc <= pc+1.
  - j=111 always jumps; j=000 never jumps.
- After COMMIT, always return to FETCH.
- write_m is 0 in every cycle except a C-COMMIT with IR[3]=1.
- out_m = result in all cycles; it is only meaningful while write_m=1.
- pc increments modulo 2^15: 0x7FFF+1 = 0x0000.
- Latency: A-instruction takes 2 cycles (FETCH, COMMIT). C-instruction takes 3 cycles (FETCH, EXEC, COMMIT), assuming instr_valid is present in FETCH.
- instr_ready is combinationally (state==FETCH) & ~reset. busy = ~(state==FETCH).
- IR[14:13] of a C-instruction are ignored.

Test Plan:
- Reset, then A-instr 0x0005 followed by C-instr 0xEC10 (D=A). Required: ALU sees zx..no=110000 and alu_y=5. After COMMIT, D=5, pc=2, write_m never asserted.
- Set D=5. Issue @7, then 0xE308 (M=D). Required: write_m is high for exactly one cycle, with address_m=7 and out_m=5.
- Set D=-1 (0xFFFF) via 0xEE90 (D=-1). Issue @20, then 0xE304 (D;JLT). Required: alu_ng=1 captured, pc=20. Repeat with D=1: pc increments, no jump.
- Issue @3, then 0xEDE8 (AM=A+1, comp 110111). Required: memory write at address 3 of value 4, A=4 afterwards.
- Hold instr_valid low for 5 cycles in FETCH. Required: state, pc and registers unchanged, instr_ready=1, busy=0.
- Assert reset during EXEC of an M=D instruction. Required: no write_m, pc=RESET_PC, A=D=0, state=FETCH on the next cycle.
